// File: rtl/signal_light_pkg.sv
// Shared definitions for the traffic-light monitor: lamp bit positions, phase encoding and widths.
package signal_light_pkg;

    localparam int RED = 2;
    localparam int YEL = 1;
    localparam int GRN = 0;

    localparam int DUR_W = 6;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        P_G1R2 = 3'd1,
        P_Y1R2 = 3'd2,
        P_R1G2 = 3'd3,
        P_R1Y2 = 3'd4
    } phase_t;

    // Legal rotation: G1R2 -> Y1R2 -> R1G2 -> R1Y2 -> G1R2.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            P_G1R2:  return P_Y1R2;
            P_Y1R2:  return P_R1G2;
            P_R1G2:  return P_R1Y2;
            P_R1Y2:  return P_G1R2;
            default: return SYNC;
        endcase
    endfunction

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/signal_light_decode.sv
// Combinational classifier of one registered lamp pair into a legal phase or a single error class.
module signal_light_decode
    import signal_light_pkg::*;
(
    input  logic [2:0] l1,
    input  logic [2:0] l2,
    output logic       legal,
    output phase_t     phase_code,
    output logic       encode_err,
    output logic       confl_err,
    output logic       allred_err
);

    // Error classes are mutually exclusive, checked in priority order.
    always_comb begin
        legal      = 1'b0;
        phase_code = SYNC;
        encode_err = 1'b0;
        confl_err  = 1'b0;
        allred_err = 1'b0;
        if (!is_onehot3(l1) || !is_onehot3(l2)) begin
            encode_err = 1'b1;
        end else if (!l1[RED] && !l2[RED]) begin
            confl_err = 1'b1;
        end else if (l1[RED] && l2[RED]) begin
            allred_err = 1'b1;
        end else begin
            legal = 1'b1;
            if (l2[RED]) begin
                phase_code = l1[GRN] ? P_G1R2 : P_Y1R2;
            end else begin
                phase_code = l2[GRN] ? P_R1G2 : P_R1Y2;
            end
        end
    end

endmodule

// File: rtl/signal_light_monitor.sv
// Passive watchdog for the two-road lamp interface: tracks phase and run length, flags
// encoding, conflict, sequence and timing violations, and accumulates an error count.
module signal_light_monitor
    import signal_light_pkg::*;
#(
    parameter int GREEN_CYC  = 15,
    parameter int YELLOW_CYC = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       light1,
    input  logic [2:0]       light2,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic [DUR_W-1:0] dur,
    output logic             err_encode,
    output logic             err_confl,
    output logic             err_seq,
    output logic             err_time,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [DUR_W-1:0] GREEN_REQ  = DUR_W'(GREEN_CYC);
    localparam logic [DUR_W-1:0] YELLOW_REQ = DUR_W'(YELLOW_CYC);
    localparam logic [DUR_W-1:0] DUR_MAX    = {DUR_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [2:0]       l1_q, l2_q;
    logic             primed_q;
    phase_t           phase_q, phase_n;
    logic [DUR_W-1:0] dur_q, dur_n;
    logic             timed_out_q, timed_out_n;
    logic             sync_seen_q, sync_seen_n;
    phase_t           sync_ref_q, sync_ref_n;
    logic             enc_q, enc_n, confl_q, confl_n, seq_q, seq_n, time_q, time_n;
    logic             sticky_q, sticky_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             any_err_n;
    logic [DUR_W-1:0] req_cur;

    logic   dec_legal, dec_enc, dec_confl, dec_allred;
    phase_t dec_phase;

    // The reset value of the input registers is not a real observation of the lamps, so
    // classification waits until one sampled value has been captured (primed_q).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1_q     <= 3'b100;
            l2_q     <= 3'b100;
            primed_q <= 1'b0;
        end else begin
            l1_q     <= light1;
            l2_q     <= light2;
            primed_q <= 1'b1;
        end
    end

    signal_light_decode u_decode (
        .l1         (l1_q),
        .l2         (l2_q),
        .legal      (dec_legal),
        .phase_code (dec_phase),
        .encode_err (dec_enc),
        .confl_err  (dec_confl),
        .allred_err (dec_allred)
    );

    assign req_cur = ((phase_q == P_Y1R2) || (phase_q == P_R1Y2)) ? YELLOW_REQ : GREEN_REQ;

    // Phase/duration FSM; in SYNC, sync_ref_q remembers the legal phase seen first so that
    // only a change to a different legal phase arms the checks.
    always_comb begin
        phase_n     = phase_q;
        dur_n       = dur_q;
        timed_out_n = timed_out_q;
        sync_seen_n = sync_seen_q;
        sync_ref_n  = sync_ref_q;
        enc_n       = 1'b0;
        confl_n     = 1'b0;
        seq_n       = 1'b0;
        time_n      = 1'b0;
        if (primed_q) begin
            if (dec_enc || dec_confl || dec_allred) begin
                enc_n       = dec_enc;
                confl_n     = dec_confl;
                seq_n       = dec_allred;
                phase_n     = SYNC;
                dur_n       = '0;
                timed_out_n = 1'b0;
                sync_seen_n = 1'b0;
            end else if (dec_legal && (phase_q == SYNC)) begin
                if (sync_seen_q && (dec_phase != sync_ref_q)) begin
                    phase_n     = dec_phase;
                    dur_n       = DUR_W'(1);
                    timed_out_n = 1'b0;
                    sync_seen_n = 1'b0;
                end else begin
                    sync_seen_n = 1'b1;
                    sync_ref_n  = dec_phase;
                    dur_n       = '0;
                end
            end else if (dec_legal && (dec_phase == phase_q)) begin
                dur_n = (dur_q == DUR_MAX) ? dur_q : dur_q + DUR_W'(1);
                if ((dur_q == req_cur) && !timed_out_q) begin
                    time_n      = 1'b1;
                    timed_out_n = 1'b1;
                end
            end else if (dec_legal) begin
                seq_n       = (dec_phase != next_phase(phase_q));
                time_n      = (dur_q < req_cur) && !timed_out_q;
                phase_n     = dec_phase;
                dur_n       = DUR_W'(1);
                timed_out_n = 1'b0;
            end
        end
    end

    // An error in the same cycle as clr_err wins: the count restarts at 1.
    always_comb begin
        any_err_n = enc_n | confl_n | seq_n | time_n;
        sticky_n  = sticky_q;
        cnt_n     = cnt_q;
        if (any_err_n) begin
            sticky_n = 1'b1;
            if (clr_err) begin
                cnt_n = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_n = cnt_q + CNT_W'(1);
            end
        end else if (clr_err) begin
            sticky_n = 1'b0;
            cnt_n    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= SYNC;
            dur_q       <= '0;
            timed_out_q <= 1'b0;
            sync_seen_q <= 1'b0;
            sync_ref_q  <= SYNC;
            enc_q       <= 1'b0;
            confl_q     <= 1'b0;
            seq_q       <= 1'b0;
            time_q      <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            phase_q     <= phase_n;
            dur_q       <= dur_n;
            timed_out_q <= timed_out_n;
            sync_seen_q <= sync_seen_n;
            sync_ref_q  <= sync_ref_n;
            enc_q       <= enc_n;
            confl_q     <= confl_n;
            seq_q       <= seq_n;
            time_q      <= time_n;
            sticky_q    <= sticky_n;
            cnt_q       <= cnt_n;
        end
    end

    assign phase      = phase_q;
    assign dur        = dur_q;
    assign err_encode = enc_q;
    assign err_confl  = confl_q;
    assign err_seq    = seq_q;
    assign err_time   = time_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_signal_light_monitor.sv
// Directed bench for signal_light_monitor with default GREEN_CYC=15, YELLOW_CYC=5.
module tb_signal_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk;
    logic       rst_n;
    logic [2:0] light1, light2;
    logic       clr_err;
    logic [2:0] phase;
    logic [5:0] dur;
    logic       err_encode, err_confl, err_seq, err_time, err_sticky;
    logic [7:0] err_cnt;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    signal_light_monitor #(.GREEN_CYC(15), .YELLOW_CYC(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .light1     (light1),
        .light2     (light2),
        .clr_err    (clr_err),
        .phase      (phase),
        .dur        (dur),
        .err_encode (err_encode),
        .err_confl  (err_confl),
        .err_seq    (err_seq),
        .err_time   (err_time),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold one lamp pair for n rising edges; returns 1 time unit after the last edge.
    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input logic clr, input int n);
        for (int i = 0; i < n; i++) begin
            light1  = a;
            light2  = b;
            clr_err = clr;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input int ph, input int dr, input int enc,
                              input int cf, input int sq, input int tm, input int st, input int cn);
        checkOutput($sformatf("%s.phase", tag),      32'(phase),      ph);
        checkOutput($sformatf("%s.dur", tag),        32'(dur),        dr);
        checkOutput($sformatf("%s.err_encode", tag), 32'(err_encode), enc);
        checkOutput($sformatf("%s.err_confl", tag),  32'(err_confl),  cf);
        checkOutput($sformatf("%s.err_seq", tag),    32'(err_seq),    sq);
        checkOutput($sformatf("%s.err_time", tag),   32'(err_time),   tm);
        checkOutput($sformatf("%s.err_sticky", tag), 32'(err_sticky), st);
        checkOutput($sformatf("%s.err_cnt", tag),    32'(err_cnt),    cn);
    endtask

    initial begin
        rst_n   = 1'b0;
        light1  = G;
        light2  = R;
        clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkState("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        $display("[TB] normal rotation");
        applyStimulus(G, R, 1'b0, 3);
        checkState("sync_first", 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(Y, R, 1'b0, 5);
        checkState("armed_y1r2", 2, 4, 0, 0, 0, 0, 0, 0);
        applyStimulus(R, G, 1'b0, 15);
        checkState("r1g2", 3, 14, 0, 0, 0, 0, 0, 0);
        applyStimulus(R, Y, 1'b0, 5);
        checkState("r1y2", 4, 4, 0, 0, 0, 0, 0, 0);
        applyStimulus(G, R, 1'b0, 15);
        checkState("g1r2", 1, 14, 0, 0, 0, 0, 0, 0);

        $display("[TB] encoding error");
        applyStimulus(3'b101, R, 1'b0, 1);
        applyStimulus(R, Y, 1'b0, 1);
        checkState("encode", 0, 0, 1, 0, 0, 0, 1, 1);
        applyStimulus(R, Y, 1'b0, 2);
        checkState("encode_after", 0, 0, 0, 0, 0, 0, 1, 1);

        $display("[TB] illegal successor");
        applyStimulus(G, R, 1'b0, 3);
        checkState("rearm_g1r2", 1, 2, 0, 0, 0, 0, 1, 1);
        applyStimulus(R, G, 1'b0, 2);
        checkState("skip_jump", 3, 1, 0, 0, 1, 1, 1, 2);

        $display("[TB] yellow overrun");
        applyStimulus(Y, R, 1'b0, 2);
        checkState("jump_y1r2", 2, 1, 0, 0, 1, 1, 1, 3);
        applyStimulus(Y, R, 1'b0, 4);
        checkState("y_dur5", 2, 5, 0, 0, 0, 0, 1, 3);
        applyStimulus(Y, R, 1'b0, 1);
        checkState("y_overrun", 2, 6, 0, 0, 0, 1, 1, 4);
        applyStimulus(Y, R, 1'b0, 2);
        checkState("y_dur8", 2, 8, 0, 0, 0, 0, 1, 4);
        applyStimulus(R, G, 1'b0, 2);
        checkState("y_exit", 3, 1, 0, 0, 0, 0, 1, 4);

        $display("[TB] conflict and all-red");
        applyStimulus(G, G, 1'b0, 1);
        applyStimulus(R, R, 1'b0, 1);
        checkState("conflict", 0, 0, 0, 1, 0, 0, 1, 5);
        applyStimulus(R, G, 1'b0, 1);
        checkState("allred", 0, 0, 0, 0, 1, 0, 1, 6);
        applyStimulus(R, G, 1'b0, 1);
        checkState("resync", 0, 0, 0, 0, 0, 0, 1, 6);

        $display("[TB] counter saturation and clear");
        applyStimulus(3'b000, R, 1'b0, 300);
        checkState("saturate", 0, 0, 1, 0, 0, 0, 1, 255);
        applyStimulus(3'b000, R, 1'b1, 1);
        checkState("clr_vs_err", 0, 0, 1, 0, 0, 0, 1, 1);
        applyStimulus(R, G, 1'b0, 1);
        checkState("count_on", 0, 0, 1, 0, 0, 0, 1, 2);
        applyStimulus(R, G, 1'b1, 1);
        checkState("clear", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] reset mid-phase");
        applyStimulus(R, Y, 1'b0, 3);
        checkState("arm_r1y2", 4, 2, 0, 0, 0, 0, 0, 0);
        applyStimulus(R, R, 1'b0, 1);
        applyStimulus(R, Y, 1'b0, 1);
        checkState("allred2", 0, 0, 0, 0, 1, 0, 1, 1);
        applyStimulus(R, Y, 1'b0, 2);
        applyStimulus(G, R, 1'b0, 2);
        checkState("arm_g1r2", 1, 1, 0, 0, 0, 0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkState("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        applyStimulus(G, R, 1'b0, 3);
        checkState("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
